// File: rtl/if_fetch.sv
// if_fetch: instruction fetch unit. Owns the PC, issues in-order word fetches
// over a req/gnt/rvalid bus and buffers returned words in a 2-entry FIFO.
// Build option IF_FETCH_PREFETCH_EN: when defined, up to two fetches may be in
// flight (credit depth 2); when undefined, a fetch is issued only with nothing
// in flight and an empty FIFO (credit depth 1).
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    output logic        ibus_req_out,
    output logic [31:0] ibus_addr_out,
    input  logic        ibus_gnt_in,
    input  logic        ibus_rvalid_in,
    input  logic [31:0] ibus_rdata_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic        inst_valid_out
);

`ifdef IF_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, DISCARD} state_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic [1:0]  outstanding;
    logic [1:0]  discard_cnt;
    logic [1:0]  fifo_cnt;
    logic [1:0]  aq_cnt;
    logic [31:0] fifo_data [2];
    logic [31:0] fifo_addr [2];
    logic [31:0] aq_addr   [2];

    logic        accept;
    logic        push;
    logic        pop;
    logic [1:0]  rsp_dec;
    logic        fifo_wr_idx;
    logic        aq_wr_idx;
    logic        unused_jaddr_bits;

    // Target is word aligned; the low address bits are ignored.
    assign unused_jaddr_bits = ^jump_addr_in[1:0];

    // Credit = in-flight fetches + buffered words; never exceed DEPTH.
    assign ibus_req_out  = (state == FETCH) && !jump_flag_in &&
                           (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'(DEPTH));
    assign ibus_addr_out = pc;
    assign accept        = ibus_req_out && ibus_gnt_in;

    // A response only counts against outstanding if one is actually pending;
    // this keeps stray responses after reset from wrapping the counter.
    assign rsp_dec = {1'b0, ibus_rvalid_in && (outstanding != 2'd0)};

    // Responses are kept only in FETCH and never in the flush cycle.
    assign push = ibus_rvalid_in && (state == FETCH) && !jump_flag_in;
    assign pop  = inst_valid_out && !stall_in && !jump_flag_in;

    // Write slot after an optional same-cycle pop shifts the head out.
    assign fifo_wr_idx = fifo_cnt[1] | (fifo_cnt[0] & ~pop);
    assign aq_wr_idx   = aq_cnt[1]   | (aq_cnt[0]   & ~push);

    assign inst_valid_out = (fifo_cnt != 2'd0);
    assign inst_out       = inst_valid_out ? fifo_data[0] : NOP;
    assign inst_addr_out  = inst_valid_out ? fifo_addr[0] : 32'd0;

    // Next-state: flush overrides everything and picks DISCARD if stale
    // responses remain after this cycle's (dropped) response.
    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = FETCH;
            DISCARD: if (ibus_rvalid_in && discard_cnt == 2'd1) state_n = FETCH;
            default: ;
        endcase
        if (jump_flag_in)
            state_n = ((outstanding - rsp_dec) != 2'd0) ? DISCARD : FETCH;
    end

    // State, PC and all occupancy counters.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            discard_cnt <= 2'd0;
            fifo_cnt    <= 2'd0;
            aq_cnt      <= 2'd0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding + {1'b0, accept} - rsp_dec;
            if (jump_flag_in) begin
                pc          <= {jump_addr_in[31:2], 2'b00};
                fifo_cnt    <= 2'd0;
                aq_cnt      <= 2'd0;
                discard_cnt <= outstanding - rsp_dec;
            end else begin
                if (accept)
                    pc <= pc + 32'd4;
                if (state == DISCARD && ibus_rvalid_in && discard_cnt != 2'd0)
                    discard_cnt <= discard_cnt - 2'd1;
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                aq_cnt   <= aq_cnt + {1'b0, accept} - {1'b0, push};
            end
        end
    end

    // Shift-register storage for the instruction FIFO and in-flight address
    // queue; a push landing in slot 0 overrides the shift from a pop.
    always_ff @(posedge clk_in) begin
        if (pop) begin
            fifo_data[0] <= fifo_data[1];
            fifo_addr[0] <= fifo_addr[1];
        end
        if (push) begin
            fifo_data[fifo_wr_idx] <= ibus_rdata_in;
            fifo_addr[fifo_wr_idx] <= aq_addr[0];
            aq_addr[0]             <= aq_addr[1];
        end
        if (accept)
            aq_addr[aq_wr_idx] <= pc;
    end

    // Credit accounting must make a push into a full FIFO impossible.
    always_ff @(posedge clk_in) begin
        if (!reset_in)
            assert (!(push && !pop && fifo_cnt == 2'd2));
    end

endmodule
